// File: rtl/iic_cmd_seq_pkg.sv
// Shared types for the I2C command sequencer: table opcodes, the ROM word
// layout and the sequencer state encoding.
package iic_pkg;

    localparam int unsigned CMD_W = 26;

    // Table opcodes as stored in the top two bits of a ROM word.
    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_DLY = 2'b10,
        OP_END = 2'b11
    } op_t;

    // ROM word: {op, dev, reg, data, last}.
    typedef struct packed {
        op_t        op;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] data;
        logic       last;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DELAY     = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage

// File: rtl/iic_cmd_seq_if.sv
// Transaction bus between the command sequencer and iic_master.
//   master modport: sequencer side (drives request, receives completion)
//   slave modport : iic_master side
interface iic_cmd_seq_if;
    logic       iic_start;
    logic [6:0] iic_dev_addr;
    logic [7:0] iic_reg_addr;
    logic       iic_wr;
    logic [7:0] iic_wdata;
    logic [7:0] iic_rdata;
    logic       iic_done;

    modport master (
        output iic_start, iic_dev_addr, iic_reg_addr, iic_wr, iic_wdata,
        input  iic_rdata, iic_done
    );

    modport slave (
        input  iic_start, iic_dev_addr, iic_reg_addr, iic_wr, iic_wdata,
        output iic_rdata, iic_done
    );
endinterface

// File: rtl/iic_cmd_seq.sv
// I2C command sequencer: walks a command table in an external synchronous ROM
// and turns each entry into an iic_master write/read, a tick-counted delay or
// the end of the sequence.
//   clk, rst       : clock, synchronous active-high reset
//   en             : global enable; low freezes the sequencer
//   tick           : bit-rate pulse used for delays and the done timeout
//   go             : start the table at entry 0 (only honoured when idle)
//   cmd_addr/data  : ROM address out, ROM word in (one cycle latency)
//   iic            : transaction bus to iic_master
//   rd_data/idx/valid : captured read byte, its table index, one-cycle strobe
//   busy, seq_done, err : status (err is sticky until rst or go)
module iic_cmd_seq
    import iic_pkg::*;
#(
    parameter int unsigned N_CMDS        = 16,
    parameter int unsigned AW            = $clog2(N_CMDS),
    parameter int unsigned TIMEOUT_TICKS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic              go,
    output logic [AW-1:0]     cmd_addr,
    input  logic [CMD_W-1:0]  cmd_data,
    iic_cmd_seq_if.master     iic,
    output logic [7:0]        rd_data,
    output logic [AW-1:0]     rd_idx,
    output logic              rd_valid,
    output logic              busy,
    output logic              seq_done,
    output logic              err
);

    // Shared counter must hold both an 8-bit delay and the timeout count.
    localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned CNT_W = (TO_W > 8) ? TO_W : 8;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(N_CMDS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

    cmd_t             cmd;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_t              op_q;
    logic             last_q;
    logic             at_end;

    logic             start_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic             wr_q;
    logic [7:0]       wdata_q;

    assign cmd = cmd_t'(cmd_data);

    // Sequence ends after a flagged entry or the last table slot.
    assign at_end = last_q || (cmd_addr == LAST_ADDR);

    assign iic.iic_start    = start_q;
    assign iic.iic_dev_addr = dev_q;
    assign iic.iic_reg_addr = reg_q;
    assign iic.iic_wr       = wr_q;
    assign iic.iic_wdata    = wdata_q;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_WR;
            last_q   <= 1'b0;
            cmd_addr <= '0;
            start_q  <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rd_data  <= '0;
            rd_idx   <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Strobes last one cycle even while frozen.
            start_q  <= 1'b0;
            rd_valid <= 1'b0;
            seq_done <= 1'b0;

            if (en) begin
                unique case (state)
                    ST_IDLE: begin
                        if (go) begin
                            cmd_addr <= '0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end

                    ST_FETCH: begin
                        state <= ST_DECODE;
                    end

                    ST_DECODE: begin
                        dev_q   <= cmd.dev;
                        reg_q   <= cmd.reg_addr;
                        wdata_q <= cmd.data;
                        wr_q    <= (cmd.op == OP_WR);
                        op_q    <= cmd.op;
                        last_q  <= cmd.last;
                        unique case (cmd.op)
                            OP_WR, OP_RD: state <= ST_ISSUE;
                            OP_DLY: begin
                                cnt   <= CNT_W'(cmd.data);
                                state <= ST_DELAY;
                            end
                            default: state <= ST_FINISH;
                        endcase
                    end

                    ST_ISSUE: begin
                        start_q <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_WAIT_DONE;
                    end

                    // Completion beats a coincident final timeout tick.
                    ST_WAIT_DONE: begin
                        if (iic.iic_done) begin
                            if (op_q == OP_RD) begin
                                rd_data  <= iic.iic_rdata;
                                rd_idx   <= cmd_addr;
                                rd_valid <= 1'b1;
                            end
                            if (at_end) begin
                                state <= ST_FINISH;
                            end else begin
                                cmd_addr <= cmd_addr + AW'(1);
                                state    <= ST_FETCH;
                            end
                        end else if (tick) begin
                            if (cnt == TO_LAST) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_DELAY: begin
                        if (cnt == '0) begin
                            if (at_end) begin
                                state <= ST_FINISH;
                            end else begin
                                cmd_addr <= cmd_addr + AW'(1);
                                state    <= ST_FETCH;
                            end
                        end else if (tick) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    ST_FINISH: begin
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
